cache_stats_collector: RTL and testbench
========================================

CACHE_STATS_COLLECTOR -- requirements
Module: cache_stats_collector

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning width of the cumulative counters.
REQ-002 SHALL have parameter WINDOW, default 256, meaning accesses per sampling window (legal range 2..65535).
REQ-003 SHALL have parameter WIN_W, default 16, meaning width of the window counters.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  collection enable.
REQ-007 SHALL have port clear  input  1  synchronous clear of all statistics.
REQ-008 SHALL have port access_valid  input  1  one cache access completes this cycle.
REQ-009 SHALL have port hit256  input  1  L1 (256-entry cache) hit flag for the access.
REQ-010 SHALL have port hit512  input  1  L2 (512-entry cache) hit flag for the access.
REQ-011 SHALL have ports l1_hits, l2_hits, misses, accesses  output  CNT_W each  cumulative counts.
REQ-012 SHALL have ports win_l1_hits, win_l2_hits, win_misses  output  WIN_W each  last completed window snapshot.
REQ-013 SHALL have port snap_valid  output  1  one-cycle pulse when a new snapshot is presented.
REQ-014 SHALL have port overflow  output  1  sticky flag; some cumulative counter saturated.

Function
REQ-015 SHALL classify an access as L1 hit when hit256=1 (hit512 ignored), L2 hit when hit256=0 and hit512=1, and miss when both are 0.
REQ-016 SHALL count an access only when access_valid=1, FSM is in RUN, and clear=0; hit flags are ignored otherwise.
REQ-017 SHALL implement FSM states IDLE and RUN: IDLE->RUN when enable=1, RUN->IDLE when enable=0; transitions take effect the following cycle.
REQ-018 SHALL, in IDLE, hold all counters and the partial window unchanged (freeze, not discard).
REQ-019 SHALL update cumulative outputs one cycle after the counted access is sampled.
REQ-020 SHALL increment accesses plus exactly one of l1_hits, l2_hits, misses per counted access.
REQ-021 SHALL saturate each cumulative counter at 2^CNT_W-1 and set overflow on the cycle any counter would wrap; overflow stays set until reset or clear.
REQ-022 SHALL keep internal window counters plus a window access index 0..WINDOW-1.
REQ-023 SHALL, when the counted access makes the index reach WINDOW, include that access in the window, copy the window counts to win_* outputs, pulse snap_valid high for exactly one cycle (the cycle after that access), and restart the window counters and index at 0.
REQ-024 SHALL hold win_* outputs stable between snapshots.
REQ-025 SHALL give clear priority over a simultaneous access: all counters, window state, win_* outputs, and overflow go to 0 the next cycle, snap_valid=0, and FSM state is unchanged.
REQ-026 SHALL let enable dropping mid-window resume the same partial window on re-enable.

Reset
REQ-027 SHALL, on reset=1 at posedge, force FSM to IDLE and all outputs (counters, win_*, snap_valid, overflow) and the window index to 0, overriding clear and access_valid.
REQ-028 SHALL discard a partial window on reset mid-operation with no snapshot pulse.

Structure
REQ-029 SHALL place the hit-class encoding (HC_L1, HC_L2, HC_MISS), the FSM state encoding, and the default CNT_W/WINDOW/WIN_W values in shared package cache_stats_pkg.
REQ-030 SHALL use one sub-module, sat_counter (parameterised width, inc, clr, saturating value, sat flag), instantiated once per cumulative counter.

Verification (WINDOW=4 unless stated)
REQ-031 SHALL cover: reset, enable=1, 3 accesses (hit256=1), (0,1), (0,0) -> l1_hits=1, l2_hits=1, misses=1, accesses=3, snap_valid never 1.
REQ-032 SHALL cover: 4 accesses (1,1),(1,0),(0,1),(0,0) -> snap_valid pulses once, 1 cycle after the 4th access, with win_l1_hits=2, win_l2_hits=1, win_misses=1; window restarts.
REQ-033 SHALL cover: 2 accesses, enable=0, 5 cycles of access_valid=1, enable=1, 2 more accesses -> accesses=4, snapshot fires after the 4th counted access.
REQ-034 SHALL cover: clear asserted together with access_valid=1 -> all counters 0 next cycle, access not counted, FSM stays RUN.
REQ-035 SHALL cover: CNT_W=4, 16 misses -> misses=15, overflow=1 from the 16th access until clear.
REQ-036 SHALL cover: reset after 3 window accesses -> all outputs 0, IDLE, no snap_valid; 4 fresh accesses produce a normal snapshot.

Source files
------------

// File: rtl/cache_stats_pkg.sv
// Shared types and defaults for the cache statistics collector.
package cache_stats_pkg;

  localparam int CNT_W_DEF  = 32;
  localparam int WINDOW_DEF = 256;
  localparam int WIN_W_DEF  = 16;

  typedef enum logic [1:0] {
    HC_L1   = 2'd0,
    HC_L2   = 2'd1,
    HC_MISS = 2'd2
  } hit_class_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // L1 wins over L2; hit512 only matters when hit256 is low.
  function automatic hit_class_e classify(input logic hit256, input logic hit512);
    if (hit256)      return HC_L1;
    else if (hit512) return HC_L2;
    else             return HC_MISS;
  endfunction

endpackage

// File: rtl/cache_stats_sat_counter.sv
// Saturating up-counter with synchronous clear; sat_o flags an increment
// that was blocked because the counter already holds its maximum value.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] value_o,
  output logic         sat_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next value: clear first, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    sat_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (&cnt_q) sat_o = 1'b1;
      else        cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/cache_stats_collector.sv
// Cache access statistics: cumulative saturating counters plus per-window
// snapshots of L1/L2/miss counts, gated by an IDLE/RUN collection FSM.
module cache_stats_collector
  import cache_stats_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WINDOW = WINDOW_DEF,
  parameter int WIN_W  = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             access_valid,
  input  logic             hit256,
  input  logic             hit512,
  output logic [CNT_W-1:0] l1_hits,
  output logic [CNT_W-1:0] l2_hits,
  output logic [CNT_W-1:0] misses,
  output logic [CNT_W-1:0] accesses,
  output logic [WIN_W-1:0] win_l1_hits,
  output logic [WIN_W-1:0] win_l2_hits,
  output logic [WIN_W-1:0] win_misses,
  output logic             snap_valid,
  output logic             overflow
);

  localparam int IDX_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

  state_e state_q, state_d;
  logic   running;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: follow enable; clear does not affect the state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable)  state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    running = 1'b0;
    if (state_q == ST_RUN) running = 1'b1;
  end

  hit_class_e hc;
  logic       count_en, is_l1, is_l2, is_miss;

  assign hc       = classify(hit256, hit512);
  assign count_en = access_valid && running && !clear;
  assign is_l1    = (hc == HC_L1);
  assign is_l2    = (hc == HC_L2);
  assign is_miss  = (hc == HC_MISS);

  logic sat_l1, sat_l2, sat_miss, sat_acc;

  sat_counter #(.W(CNT_W)) u_cnt_l1 (
    .clk(clk), .reset(reset), .clr_i(clear), .inc_i(count_en && is_l1),
    .value_o(l1_hits), .sat_o(sat_l1)
  );
  sat_counter #(.W(CNT_W)) u_cnt_l2 (
    .clk(clk), .reset(reset), .clr_i(clear), .inc_i(count_en && is_l2),
    .value_o(l2_hits), .sat_o(sat_l2)
  );
  sat_counter #(.W(CNT_W)) u_cnt_miss (
    .clk(clk), .reset(reset), .clr_i(clear), .inc_i(count_en && is_miss),
    .value_o(misses), .sat_o(sat_miss)
  );
  sat_counter #(.W(CNT_W)) u_cnt_acc (
    .clk(clk), .reset(reset), .clr_i(clear), .inc_i(count_en),
    .value_o(accesses), .sat_o(sat_acc)
  );

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIN_W-1:0] wl1_q, wl1_d, wl2_q, wl2_d, wmiss_q, wmiss_d;
  logic [WIN_W-1:0] snl1_q, snl1_d, snl2_q, snl2_d, snmiss_q, snmiss_d;
  logic [WIN_W-1:0] wl1_inc, wl2_inc, wmiss_inc;
  logic             snap_q, snap_d;
  logic             ovf_q, ovf_d;

  assign wl1_inc   = wl1_q   + WIN_W'(is_l1);
  assign wl2_inc   = wl2_q   + WIN_W'(is_l2);
  assign wmiss_inc = wmiss_q + WIN_W'(is_miss);

  // Window accumulation, snapshot on the last access of a window, sticky overflow.
  always_comb begin
    idx_d    = idx_q;
    wl1_d    = wl1_q;
    wl2_d    = wl2_q;
    wmiss_d  = wmiss_q;
    snl1_d   = snl1_q;
    snl2_d   = snl2_q;
    snmiss_d = snmiss_q;
    snap_d   = 1'b0;
    ovf_d    = ovf_q | sat_l1 | sat_l2 | sat_miss | sat_acc;
    if (clear) begin
      idx_d    = '0;
      wl1_d    = '0;
      wl2_d    = '0;
      wmiss_d  = '0;
      snl1_d   = '0;
      snl2_d   = '0;
      snmiss_d = '0;
      ovf_d    = 1'b0;
    end else if (count_en) begin
      if (idx_q == LAST_IDX) begin
        snl1_d   = wl1_inc;
        snl2_d   = wl2_inc;
        snmiss_d = wmiss_inc;
        snap_d   = 1'b1;
        idx_d    = '0;
        wl1_d    = '0;
        wl2_d    = '0;
        wmiss_d  = '0;
      end else begin
        idx_d    = idx_q + IDX_W'(1);
        wl1_d    = wl1_inc;
        wl2_d    = wl2_inc;
        wmiss_d  = wmiss_inc;
      end
    end
  end

  // Window and snapshot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= '0;
      wl1_q    <= '0;
      wl2_q    <= '0;
      wmiss_q  <= '0;
      snl1_q   <= '0;
      snl2_q   <= '0;
      snmiss_q <= '0;
      snap_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      wl1_q    <= wl1_d;
      wl2_q    <= wl2_d;
      wmiss_q  <= wmiss_d;
      snl1_q   <= snl1_d;
      snl2_q   <= snl2_d;
      snmiss_q <= snmiss_d;
      snap_q   <= snap_d;
      ovf_q    <= ovf_d;
    end
  end

  assign win_l1_hits = snl1_q;
  assign win_l2_hits = snl2_q;
  assign win_misses  = snmiss_q;
  assign snap_valid  = snap_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_cache_stats_collector.sv
// Directed bench: a WINDOW=4 instance with wide counters and a WINDOW=4,
// CNT_W=4 instance for saturation, both driven by the same inputs.
module tb_cache_stats_collector;

  logic clk = 1'b0;
  logic reset, enable, clear, access_valid, hit256, hit512;

  logic [31:0] l1_hits, l2_hits, misses, accesses;
  logic [15:0] win_l1_hits, win_l2_hits, win_misses;
  logic        snap_valid, overflow;

  logic [3:0]  s_l1_hits, s_l2_hits, s_misses, s_accesses;
  logic [15:0] s_win_l1_hits, s_win_l2_hits, s_win_misses;
  logic        s_snap_valid, s_overflow;

  int n_checks = 0;
  int n_errors = 0;
  int snap_cnt = 0;

  always #5 clk = ~clk;

  cache_stats_collector #(.CNT_W(32), .WINDOW(4), .WIN_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .access_valid(access_valid), .hit256(hit256), .hit512(hit512),
    .l1_hits(l1_hits), .l2_hits(l2_hits), .misses(misses), .accesses(accesses),
    .win_l1_hits(win_l1_hits), .win_l2_hits(win_l2_hits), .win_misses(win_misses),
    .snap_valid(snap_valid), .overflow(overflow)
  );

  cache_stats_collector #(.CNT_W(4), .WINDOW(4), .WIN_W(16)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .access_valid(access_valid), .hit256(hit256), .hit512(hit512),
    .l1_hits(s_l1_hits), .l2_hits(s_l2_hits), .misses(s_misses), .accesses(s_accesses),
    .win_l1_hits(s_win_l1_hits), .win_l2_hits(s_win_l2_hits), .win_misses(s_win_misses),
    .snap_valid(s_snap_valid), .overflow(s_overflow)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (snap_valid) snap_cnt++;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; clear = 1'b0;
    access_valid = 1'b0; hit256 = 1'b0; hit512 = 1'b0;
    tick();
    reset = 1'b0;
    snap_cnt = 0;
  endtask

  task automatic start_run();
    enable = 1'b1;
    tick();
  endtask

  task automatic acc(input logic h256, input logic h512);
    access_valid = 1'b1; hit256 = h256; hit512 = h512;
    tick();
    access_valid = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    check_eq("rst_l1", l1_hits, 0);
    check_eq("rst_l2", l2_hits, 0);
    check_eq("rst_miss", misses, 0);
    check_eq("rst_acc", accesses, 0);
    check_eq("rst_wl1", win_l1_hits, 0);
    check_eq("rst_snap", snap_valid, 0);
    check_eq("rst_ovf", overflow, 0);

    // three accesses, one of each class, no snapshot
    start_run();
    acc(1, 0); acc(0, 1); acc(0, 0);
    check_eq("t1_l1", l1_hits, 1);
    check_eq("t1_l2", l2_hits, 1);
    check_eq("t1_miss", misses, 1);
    check_eq("t1_acc", accesses, 3);
    check_eq("t1_snaps", snap_cnt, 0);

    // full window, hit512 ignored when hit256 set
    do_reset();
    start_run();
    acc(1, 1); acc(1, 0); acc(0, 1);
    check_eq("t2_snap_early", snap_valid, 0);
    acc(0, 0);
    check_eq("t2_snap", snap_valid, 1);
    check_eq("t2_wl1", win_l1_hits, 2);
    check_eq("t2_wl2", win_l2_hits, 1);
    check_eq("t2_wmiss", win_misses, 1);
    check_eq("t2_l1", l1_hits, 2);
    tick();
    check_eq("t2_snap_pulse", snap_valid, 0);
    check_eq("t2_wl1_hold", win_l1_hits, 2);
    acc(0, 0);
    check_eq("t2_acc5", accesses, 5);
    check_eq("t2_wmiss_hold", win_misses, 1);
    acc(0, 1); acc(0, 1); acc(0, 1);
    check_eq("t2_snap2", snap_valid, 1);
    check_eq("t2_wl1_b", win_l1_hits, 0);
    check_eq("t2_wl2_b", win_l2_hits, 3);
    check_eq("t2_wmiss_b", win_misses, 1);
    check_eq("t2_snaps", snap_cnt, 2);

    // pause mid-window and resume the same window
    do_reset();
    start_run();
    acc(1, 0); acc(1, 0);
    enable = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) acc(0, 0);
    check_eq("t3_acc_frozen", accesses, 2);
    check_eq("t3_miss_frozen", misses, 0);
    enable = 1'b1;
    tick();
    acc(0, 1);
    check_eq("t3_snap_early", snap_valid, 0);
    acc(0, 1);
    check_eq("t3_snap", snap_valid, 1);
    check_eq("t3_acc", accesses, 4);
    check_eq("t3_wl1", win_l1_hits, 2);
    check_eq("t3_wl2", win_l2_hits, 2);
    check_eq("t3_snaps", snap_cnt, 1);

    // clear beats a simultaneous access, FSM stays in RUN
    do_reset();
    start_run();
    for (int i = 0; i < 5; i++) acc(1, 0);
    check_eq("t4_wl1_pre", win_l1_hits, 4);
    clear = 1'b1;
    acc(1, 0);
    clear = 1'b0;
    check_eq("t4_l1", l1_hits, 0);
    check_eq("t4_acc", accesses, 0);
    check_eq("t4_wl1", win_l1_hits, 0);
    check_eq("t4_snap", snap_valid, 0);
    acc(0, 0);
    check_eq("t4_run_kept", accesses, 1);
    acc(0, 0); acc(0, 0);
    check_eq("t4_snap_early", snap_valid, 0);
    acc(0, 0);
    check_eq("t4_snap2", snap_valid, 1);
    check_eq("t4_wmiss", win_misses, 4);
    check_eq("t4_wl1_b", win_l1_hits, 0);

    // saturation on the 4-bit instance
    do_reset();
    start_run();
    for (int i = 0; i < 15; i++) acc(0, 0);
    check_eq("t5_miss15", s_misses, 15);
    check_eq("t5_acc15", s_accesses, 15);
    check_eq("t5_ovf_pre", s_overflow, 0);
    acc(0, 0);
    check_eq("t5_miss_sat", s_misses, 15);
    check_eq("t5_ovf", s_overflow, 1);
    acc(0, 0);
    check_eq("t5_ovf_sticky", s_overflow, 1);
    check_eq("t5_wide_miss", misses, 17);
    check_eq("t5_wide_ovf", overflow, 0);
    check_eq("t5_l1_zero", s_l1_hits, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("t5_ovf_clr", s_overflow, 0);
    check_eq("t5_miss_clr", s_misses, 0);

    // reset mid-window discards the partial window
    do_reset();
    start_run();
    acc(1, 0); acc(0, 1); acc(0, 0);
    reset = 1'b1;
    access_valid = 1'b1; hit256 = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t6_acc", accesses, 0);
    check_eq("t6_l1", l1_hits, 0);
    check_eq("t6_snap", snap_valid, 0);
    check_eq("t6_snaps", snap_cnt, 0);
    access_valid = 1'b1;
    tick();
    access_valid = 1'b0;
    check_eq("t6_idle", accesses, 0);
    acc(0, 1);
    check_eq("t6_snap_early", snap_valid, 0);
    acc(0, 1); acc(1, 0); acc(0, 0);
    check_eq("t6_snap2", snap_valid, 1);
    check_eq("t6_wl1", win_l1_hits, 1);
    check_eq("t6_wl2", win_l2_hits, 2);
    check_eq("t6_wmiss", win_misses, 1);
    check_eq("t6_acc4", accesses, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
